// File: rtl/reg_load_pkg.sv
// Shared types and constants for the register-bank write arbiter.
package reg_load_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned DEF_WIDTH = 4;
    localparam int unsigned DEF_NREG  = 4;
    localparam int unsigned DEF_NREQ  = 2;

    // Index width for n items, never narrower than one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 32'd1) ? 32'd1 : 32'($clog2(n));
    endfunction

endpackage

// File: rtl/reg_load_arbiter_rr.sv
// Combinational round-robin picker: first set request at or above ptr, with wrap.
module rr_arbiter
    import reg_load_pkg::*;
#(
    parameter  int unsigned NREQ = DEF_NREQ,
    localparam int unsigned PW   = clog2_min1(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   idx,
    output logic            valid
);

    always_comb begin
        int unsigned k;
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        k     = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            k = (32'(ptr) + i) % NREQ;
            if (!valid && req[k]) begin
                valid    = 1'b1;
                grant[k] = 1'b1;
                idx      = PW'(k);
            end
        end
    end

endmodule

// File: rtl/reg_load_arbiter.sv
// Round-robin write arbiter driving a one-hot clock-enable and shared data bus
// into a register bank that runs entirely on CLK.
module reg_load_arbiter
    import reg_load_pkg::*;
#(
    parameter  int unsigned WIDTH = DEF_WIDTH,
    parameter  int unsigned NREG  = DEF_NREG,
    parameter  int unsigned NREQ  = DEF_NREQ,
    localparam int unsigned AW    = clog2_min1(NREG),
    localparam int unsigned PW    = clog2_min1(NREQ)
) (
    input  logic                    CLK,
    input  logic                    RESETN,
    input  logic [NREQ-1:0]         REQ,
    input  logic [NREQ*AW-1:0]      ADDR,
    input  logic [NREQ*WIDTH-1:0]   DATA,
    output logic [NREQ-1:0]         ACK,
    output logic [NREG-1:0]         CE,
    output logic [WIDTH-1:0]        D,
    output logic                    BUSY
);

    state_t             state;
    logic [PW-1:0]      ptr;
    logic [PW-1:0]      win_idx;
    logic [NREQ-1:0]    win_oh;

    logic [NREQ-1:0]    grant_c;
    logic [PW-1:0]      idx_c;
    logic               valid_c;
    logic [AW-1:0]      addr_sel_c;
    logic [WIDTH-1:0]   data_sel_c;
    logic [NREG-1:0]    ce_dec_c;
    logic [PW-1:0]      ptr_next_c;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req   (REQ),
        .ptr   (ptr),
        .grant (grant_c),
        .idx   (idx_c),
        .valid (valid_c)
    );

    // Winner's slices and CE decode; addresses beyond the bank decode to all-zero.
    always_comb begin
        addr_sel_c = ADDR[32'(idx_c) * AW +: AW];
        data_sel_c = DATA[32'(idx_c) * WIDTH +: WIDTH];
        ce_dec_c   = '0;
        for (int unsigned r = 0; r < NREG; r++) begin
            ce_dec_c[r] = (32'(addr_sel_c) == r);
        end
        ptr_next_c = PW'((32'(win_idx) + 32'd1) % NREQ);
    end

    // FSM, pointer and registered outputs; CE/D are loaded on entry to LOAD so
    // they are valid for exactly the LOAD cycle.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state   <= IDLE;
            ptr     <= '0;
            win_idx <= '0;
            win_oh  <= '0;
            ACK     <= '0;
            CE      <= '0;
            D       <= '0;
            BUSY    <= 1'b0;
        end else begin
            ACK <= '0;
            CE  <= '0;
            unique case (state)
                IDLE: begin
                    if (valid_c) begin
                        state   <= LOAD;
                        win_idx <= idx_c;
                        win_oh  <= grant_c;
                        CE      <= ce_dec_c;
                        D       <= data_sel_c;
                        BUSY    <= 1'b1;
                    end
                end
                LOAD: begin
                    state <= DONE;
                    ACK   <= win_oh;
                end
                DONE: begin
                    state <= IDLE;
                    ptr   <= ptr_next_c;
                    BUSY  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_load_arbiter.sv
// Self-checking bench for reg_load_arbiter with a transaction-level reference model.
module tb_reg_load_arbiter;

    localparam int unsigned W   = 4;
    localparam int unsigned NR  = 4;
    localparam int unsigned NQ  = 2;
    localparam int unsigned AWD = 2;

    logic               CLK = 1'b0;
    logic               RESETN;
    logic [NQ-1:0]      req;
    logic [NQ*AWD-1:0]  addr;
    logic [NQ*W-1:0]    data;
    logic [NQ-1:0]      ack;
    logic [NR-1:0]      ce;
    logic [W-1:0]       d;
    logic               busy;

    logic [NQ-1:0]      req3;
    logic [NQ*2-1:0]    addr3;
    logic [NQ*W-1:0]    data3;
    logic [NQ-1:0]      ack3;
    logic [2:0]         ce3;
    logic [W-1:0]       d3;
    logic               busy3;

    int checks = 0;
    int failures = 0;

    int m_ptr;
    int m_bank [NR];
    logic [W-1:0] bank [NR];
    logic bank_init = 1'b0;

    always #5 CLK = ~CLK;

    reg_load_arbiter #(.WIDTH(W), .NREG(NR), .NREQ(NQ)) u_dut (
        .CLK(CLK), .RESETN(RESETN), .REQ(req), .ADDR(addr), .DATA(data),
        .ACK(ack), .CE(ce), .D(d), .BUSY(busy)
    );

    reg_load_arbiter #(.WIDTH(W), .NREG(3), .NREQ(NQ)) u_dut3 (
        .CLK(CLK), .RESETN(RESETN), .REQ(req3), .ADDR(addr3), .DATA(data3),
        .ACK(ack3), .CE(ce3), .D(d3), .BUSY(busy3)
    );

    // Register bank behind the arbiter: captures D on any enabled entry.
    always @(posedge CLK) begin
        for (int r = 0; r < NR; r++) begin
            if (!bank_init) bank[r] <= '0;
            else if (ce[r]) bank[r] <= d;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One full transaction on u_dut for whatever is currently requested.
    // mode 0: inputs stable, 1: randomise ADDR/DATA during LOAD, 2: DATA0 -> 9 during LOAD.
    task automatic serve(input string tag, input int mode, output logic [NQ-1:0] ack_seen);
        int w;
        int a;
        int dv;
        logic [NR-1:0] exp_ce;
        logic [NQ-1:0] exp_ack;
        w = -1;
        for (int i = 0; i < NQ; i++) begin
            int k;
            k = (m_ptr + i) % NQ;
            if (w < 0 && req[k]) w = k;
        end
        a  = int'(addr[w*AWD +: AWD]);
        dv = int'(data[w*W +: W]);
        exp_ce = '0;
        if (a < NR) exp_ce[a] = 1'b1;
        exp_ack = '0;
        exp_ack[w] = 1'b1;

        tick();
        checks++;
        if (ce !== exp_ce) begin failures++; $display("FAIL %s load_ce got %b exp %b", tag, ce, exp_ce); end
        checks++;
        if (d !== W'(dv)) begin failures++; $display("FAIL %s load_d got %h exp %h", tag, d, W'(dv)); end
        checks++;
        if (ack !== '0 || busy !== 1'b1) begin
            failures++; $display("FAIL %s load_ack_busy got %b/%b exp 00/1", tag, ack, busy);
        end
        if (mode == 1) begin
            addr = NQ*AWD'($urandom);
            data = NQ*W'($urandom);
        end else if (mode == 2) begin
            data[W-1:0] = 4'h9;
        end

        tick();
        ack_seen = ack;
        checks++;
        if (ack !== exp_ack) begin failures++; $display("FAIL %s done_ack got %b exp %b", tag, ack, exp_ack); end
        checks++;
        if (ce !== '0 || busy !== 1'b1) begin
            failures++; $display("FAIL %s done_ce_busy got %b/%b exp 0000/1", tag, ce, busy);
        end
        if (a < NR) m_bank[a] = dv;
        m_ptr = (w + 1) % NQ;
        req[w] = 1'b0;

        tick();
        checks++;
        if (ack !== '0 || busy !== 1'b0) begin
            failures++; $display("FAIL %s idle_ack_busy got %b/%b exp 00/0", tag, ack, busy);
        end
        for (int r = 0; r < NR; r++) begin
            checks++;
            if (bank[r] !== W'(m_bank[r])) begin
                failures++; $display("FAIL %s bank%0d got %h exp %h", tag, r, bank[r], W'(m_bank[r]));
            end
        end
    endtask

    task automatic pulse_reset();
        RESETN = 1'b0;
        tick();
        RESETN = 1'b1;
        m_ptr = 0;
    endtask

    task automatic test_reset();
        RESETN = 1'b0;
        req = '0; addr = '0; data = '0;
        req3 = '0; addr3 = '0; data3 = '0;
        m_ptr = 0;
        for (int r = 0; r < NR; r++) m_bank[r] = 0;
        tick();
        tick();
        bank_init = 1'b1;
        checks++;
        if (ack !== '0 || ce !== '0 || d !== '0 || busy !== 1'b0) begin
            failures++; $display("FAIL reset outputs got ack=%b ce=%b d=%h busy=%b exp all 0", ack, ce, d, busy);
        end
        checks++;
        if (ack3 !== '0 || ce3 !== '0 || d3 !== '0 || busy3 !== 1'b0) begin
            failures++; $display("FAIL reset3 outputs got ack=%b ce=%b d=%h busy=%b exp all 0", ack3, ce3, d3, busy3);
        end
        RESETN = 1'b1;
        repeat (3) begin
            tick();
            checks++;
            if (ce !== '0 || busy !== 1'b0 || ack !== '0) begin
                failures++; $display("FAIL idle_quiet got ce=%b busy=%b ack=%b exp 0", ce, busy, ack);
            end
        end
    endtask

    task automatic test_single();
        logic [NQ-1:0] a;
        req = 2'b01; addr = 4'b00_10; data = 8'h0A;
        serve("single", 0, a);
    endtask

    task automatic test_contention();
        logic [NQ-1:0] a;
        pulse_reset();
        req = 2'b11; addr = 4'b11_00; data = 8'hC5;
        serve("contend0", 0, a);
        serve("contend1", 0, a);
    endtask

    task automatic test_fairness();
        logic [NQ-1:0] a;
        for (int i = 0; i < 6; i++) begin
            req = 2'b11;
            addr = NQ*AWD'($urandom);
            data = NQ*W'($urandom);
            serve("fair", 0, a);
            checks++;
            if (a !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
                failures++; $display("FAIL fair_pattern i=%0d got %b exp %b", i, a, (i % 2 == 0) ? 2'b01 : 2'b10);
            end
        end
    endtask

    task automatic test_reset_in_load();
        req = 2'b01; addr = 4'b00_01; data = 8'h0F;
        tick();
        checks++;
        if (ce !== 4'b0010) begin failures++; $display("FAIL rstload_pre ce got %b exp 0010", ce); end
        RESETN = 1'b0;
        #1;
        checks++;
        if (ce !== '0 || busy !== 1'b0 || ack !== '0) begin
            failures++; $display("FAIL rstload_async got ce=%b busy=%b ack=%b exp 0", ce, busy, ack);
        end
        req = '0;
        tick();
        RESETN = 1'b1;
        m_ptr = 0;
        repeat (3) begin
            tick();
            checks++;
            if (ack !== '0 || ce !== '0) begin
                failures++; $display("FAIL rstload_noack got ack=%b ce=%b exp 0", ack, ce);
            end
        end
        checks++;
        if (bank[1] !== W'(m_bank[1])) begin
            failures++; $display("FAIL rstload_bank1 got %h exp %h", bank[1], W'(m_bank[1]));
        end
    endtask

    task automatic test_out_of_range();
        req3 = 2'b01; addr3 = 4'b00_11; data3 = 8'h07;
        tick();
        checks++;
        if (ce3 !== 3'b000 || busy3 !== 1'b1) begin
            failures++; $display("FAIL oor_load got ce=%b busy=%b exp 000/1", ce3, busy3);
        end
        tick();
        checks++;
        if (ack3 !== 2'b01 || ce3 !== 3'b000) begin
            failures++; $display("FAIL oor_ack got ack=%b ce=%b exp 01/000", ack3, ce3);
        end
        req3 = '0;
        tick();
        checks++;
        if (ack3 !== '0 || busy3 !== 1'b0) begin
            failures++; $display("FAIL oor_idle got ack=%b busy=%b exp 00/0", ack3, busy3);
        end
    endtask

    task automatic test_midflight_change();
        logic [NQ-1:0] a;
        req = 2'b01; addr = 4'b00_11; data = 8'h03;
        serve("midflight", 2, a);
    endtask

    task automatic test_random();
        logic [NQ-1:0] a;
        for (int n = 0; n < 25; n++) begin
            int guard;
            req  = NQ'($urandom_range(1, 3));
            addr = NQ*AWD'($urandom);
            data = NQ*W'($urandom);
            guard = 0;
            while (req != '0 && guard < 4) begin
                serve("random", int'($urandom_range(0, 1)), a);
                guard++;
            end
            checks++;
            if (req != '0) begin failures++; $display("FAIL random_drain req left %b exp 00", req); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_fairness();
        test_reset_in_load();
        test_out_of_range();
        test_midflight_change();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
